// File: rtl/tcm_ctrl_if.sv
// Command/response bus between a requester and the TCM controller.
// The controller takes the slave modport; the requester takes the master modport.
interface tcm_ctrl_if #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int MW = 4
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic [AW-1:0] cmd_addr;
  logic          cmd_read;
  logic [DW-1:0] cmd_wdata;
  logic [MW-1:0] cmd_wmask;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;

  modport master (
    output cmd_valid, cmd_addr, cmd_read, cmd_wdata, cmd_wmask, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_addr, cmd_read, cmd_wdata, cmd_wmask, rsp_ready,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/tcm_ctrl.sv
// Valid/ready front end for a single-port, one-cycle-latency TCM SRAM.
// Define TCM_ERR_EN to enable range/alignment checking with error responses.
module tcm_ctrl #(
  parameter int DP = 512,
  parameter int DW = 32,
  parameter int MW = 4,
  parameter int AW = 32,
  parameter int RAM_AW = 9,
  parameter logic [AW-1:0] BASE_ADDR = 32'h8000_0000
) (
  input  logic              clk,
  input  logic              rst,
  tcm_ctrl_if.slave         bus,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [DW-1:0]     ram_din,
  output logic              ram_we,
  output logic [MW-1:0]     ram_wem,
  input  logic [DW-1:0]     ram_dout
);

  logic              s1_valid;
  logic              s1_read;
  logic              s1_err;
  logic [RAM_AW-1:0] last_raddr;
  logic [RAM_AW-1:0] word_idx;
  logic              accept;
  logic              cmd_err;

  assign word_idx = bus.cmd_addr[RAM_AW+1:2];

`ifdef TCM_ERR_EN
  localparam logic [AW:0] END_ADDR = {1'b0, BASE_ADDR} + (AW+1)'(DP * 4);

  assign cmd_err = (bus.cmd_addr < BASE_ADDR)
                 | ({1'b0, bus.cmd_addr} >= END_ADDR)
                 | (bus.cmd_addr[1:0] != 2'b00);
`else
  logic unused_addr_bits;

  // Upper and byte-offset address bits are deliberately ignored; the window wraps.
  assign unused_addr_bits = ^{bus.cmd_addr[AW-1:RAM_AW+2], bus.cmd_addr[1:0]};
  assign cmd_err = 1'b0;
`endif

  assign bus.cmd_ready = ~rst & (~s1_valid | bus.rsp_ready);
  assign accept        = bus.cmd_valid & bus.cmd_ready;

  // When idle or rejecting, re-present the last read address so ram_dout holds.
  always_comb begin
    ram_addr = last_raddr;
    ram_din  = '0;
    ram_we   = 1'b0;
    ram_wem  = '0;
    if (rst) begin
      ram_addr = '0;
    end else if (accept && !cmd_err) begin
      ram_addr = word_idx;
      ram_din  = bus.cmd_wdata;
      ram_wem  = bus.cmd_wmask;
      ram_we   = ~bus.cmd_read;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid   <= 1'b0;
      s1_read    <= 1'b0;
      s1_err     <= 1'b0;
      last_raddr <= '0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_read  <= bus.cmd_read;
      s1_err   <= cmd_err;
      if (bus.cmd_read && !cmd_err) begin
        last_raddr <= word_idx;
      end
    end else if (s1_valid && bus.rsp_ready) begin
      s1_valid <= 1'b0;
    end
  end

  assign bus.rsp_valid = s1_valid;
  assign bus.rsp_rdata = (s1_valid & s1_read & ~s1_err) ? ram_dout : '0;
  assign bus.rsp_err   = s1_valid & s1_err;

endmodule

// File: tb/tb_tcm_ctrl.sv
// Randomized self-checking bench for tcm_ctrl against a transaction-level model.
// Compile with TCM_ERR_EN defined to also exercise the error-response path.
module tb_tcm_ctrl;
  localparam int DP = 512;
  localparam logic [31:0] BASE = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [8:0]  ram_addr;
  logic [31:0] ram_din;
  logic        ram_we;
  logic [3:0]  ram_wem;
  logic [31:0] ram_dout;

  tcm_ctrl_if #(.AW(32), .DW(32), .MW(4)) bus ();

  tcm_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .ram_addr (ram_addr),
    .ram_din  (ram_din),
    .ram_we   (ram_we),
    .ram_wem  (ram_wem),
    .ram_dout (ram_dout)
  );

  always #5 clk = ~clk;

  // Single-port SRAM: masked write when we=1, otherwise latch the read address.
  logic [31:0] sram [DP];
  always @(posedge clk) begin
    if (ram_we) begin
      for (int b = 0; b < 4; b++)
        if (ram_wem[b]) sram[ram_addr][8*b +: 8] <= ram_din[8*b +: 8];
    end else begin
      ram_dout <= sram[ram_addr];
    end
  end

  int total = 0;
  int bad = 0;

  logic [31:0] ref_mem [DP];
  logic [31:0] exp_data_q [$];
  logic        exp_err_q [$];
  logic [31:0] last_pop_data;
  logic        last_pop_err;
  bit          prev_rst = 1'b0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic addr_err(input logic [31:0] a);
`ifdef TCM_ERR_EN
    return (a < BASE) || (a >= BASE + DP * 4) || (a[1:0] != 2'b00);
`else
    return 1'b0;
`endif
  endfunction

  // One bus cycle: drive at the falling edge, check settled outputs, advance the model.
  task automatic applyStimulus(input bit v, input bit rd, input logic [31:0] a,
                               input logic [31:0] wd, input logic [3:0] wm,
                               input bit rr, input bit rs);
    bit          exp_rdy;
    logic        err;
    logic [8:0]  idx;
    @(negedge clk);
    rst           = rs;
    bus.cmd_valid = v;
    bus.cmd_read  = rd;
    bus.cmd_addr  = a;
    bus.cmd_wdata = wd;
    bus.cmd_wmask = wm;
    bus.rsp_ready = rr;
    #1;
    if (rs) begin
      checkOutput("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
      checkOutput("rst_ram_we", 32'(ram_we), 32'd0);
      checkOutput("rst_ram_addr", 32'(ram_addr), 32'd0);
      if (prev_rst) begin
        checkOutput("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        checkOutput("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
        checkOutput("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
      end
      exp_data_q.delete();
      exp_err_q.delete();
    end else begin
      exp_rdy = (exp_data_q.size() == 0) || rr;
      checkOutput("cmd_ready", 32'(bus.cmd_ready), 32'(exp_rdy));
      checkOutput("rsp_valid", 32'(bus.rsp_valid), 32'(exp_data_q.size() != 0));
      if (exp_data_q.size() != 0) begin
        checkOutput("rsp_rdata", bus.rsp_rdata, exp_data_q[0]);
        checkOutput("rsp_err", 32'(bus.rsp_err), 32'(exp_err_q[0]));
        if (rr) begin
          last_pop_data = exp_data_q.pop_front();
          last_pop_err  = exp_err_q.pop_front();
        end
      end
      if (v && exp_rdy) begin
        err = addr_err(a);
        idx = a[10:2];
        checkOutput("ram_we_acc", 32'(ram_we), 32'(!rd && !err));
        if (!err) checkOutput("ram_addr_acc", 32'(ram_addr), 32'(idx));
        if (err) begin
          exp_data_q.push_back(32'd0);
        end else if (rd) begin
          exp_data_q.push_back(ref_mem[idx]);
        end else begin
          for (int b = 0; b < 4; b++)
            if (wm[b]) ref_mem[idx][8*b +: 8] = wd[8*b +: 8];
          exp_data_q.push_back(32'd0);
        end
        exp_err_q.push_back(err);
      end else begin
        checkOutput("ram_we_idle", 32'(ram_we), 32'd0);
      end
    end
    prev_rst = rs;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 1, 32'd0, 32'd0, 4'd0, 1, 0);
  endtask

  initial begin
    logic [31:0] a;
    for (int i = 0; i < DP; i++) begin
      sram[i]    = 32'd0;
      ref_mem[i] = 32'd0;
    end
    rst = 1'b1;
    bus.cmd_valid = 0; bus.cmd_read = 1; bus.cmd_addr = 0;
    bus.cmd_wdata = 0; bus.cmd_wmask = 0; bus.rsp_ready = 1;

    applyStimulus(0, 1, 32'd0, 32'd0, 4'd0, 1, 1);
    applyStimulus(0, 1, 32'd0, 32'd0, 4'd0, 1, 1);
    idle(1);

    // Back-to-back stream: write word 3, read word 3, read word 4.
    applyStimulus(1, 0, BASE + 32'hC,  32'hA5A5_A5A5, 4'hF, 1, 0);
    applyStimulus(1, 1, BASE + 32'hC,  32'd0, 4'd0, 1, 0);
    checkOutput("b2b_wr_rsp", last_pop_data, 32'd0);
    applyStimulus(1, 1, BASE + 32'h10, 32'd0, 4'd0, 1, 0);
    checkOutput("b2b_rd3", last_pop_data, 32'hA5A5_A5A5);
    idle(1);
    checkOutput("b2b_rd4", last_pop_data, 32'd0);

    applyStimulus(1, 0, BASE + 32'h10, 32'hDEAD_BEEF, 4'hF, 1, 0);
    applyStimulus(1, 1, BASE + 32'h10, 32'd0, 4'd0, 1, 0);
    idle(1);
    checkOutput("raw_full", last_pop_data, 32'hDEAD_BEEF);
    applyStimulus(1, 0, BASE + 32'h10, 32'h1122_3344, 4'b0101, 1, 0);
    applyStimulus(1, 1, BASE + 32'h10, 32'd0, 4'd0, 1, 0);
    idle(1);
    checkOutput("raw_masked", last_pop_data, 32'hDE22_BE44);

    // Stalled read with a competing write offered every cycle.
    applyStimulus(1, 1, BASE + 32'h10, 32'd0, 4'd0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, 0, BASE + 32'h20, 32'hFFFF_FFFF, 4'hF, 0, 0);
      checkOutput("stall_rdata", bus.rsp_rdata, 32'hDE22_BE44);
      checkOutput("stall_addr", 32'(ram_addr), 32'd4);
    end
    idle(1);

    // Zero-mask write leaves memory unchanged.
    applyStimulus(1, 0, BASE + 32'h10, 32'h0BAD_0BAD, 4'h0, 1, 0);
    applyStimulus(1, 1, BASE + 32'h10, 32'd0, 4'd0, 1, 0);
    idle(1);
    checkOutput("zero_mask", last_pop_data, 32'hDE22_BE44);

    // Reset while a read response is pending.
    applyStimulus(1, 1, BASE + 32'hC, 32'd0, 4'd0, 0, 0);
    applyStimulus(0, 1, 32'd0, 32'd0, 4'd0, 0, 1);
    idle(3);

    applyStimulus(1, 1, 32'h9000_0000, 32'd0, 4'd0, 1, 0);
    applyStimulus(1, 0, BASE + 32'h2, 32'h7777_7777, 4'hF, 1, 0);
    applyStimulus(1, 1, BASE + 32'h10, 32'd0, 4'd0, 1, 0);
    idle(1);
    checkOutput("after_err_rd", last_pop_data, 32'hDE22_BE44);
    checkOutput("after_err_flag", 32'(last_pop_err), 32'd0);

    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 9))
        0:       a = $urandom;
        1:       a = BASE + $urandom_range(0, 15) * 4 + $urandom_range(1, 3);
        2:       a = BASE + DP * 4 + $urandom_range(0, 7) * 4;
        default: a = BASE + $urandom_range(0, 15) * 4;
      endcase
      applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, a, $urandom,
                    4'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 199) == 0);
    end
    idle(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
